// File: rtl/midi_pkg.sv
// midi_pkg -- shared MIDI status-class constants, parser state type and the
// helper that tells how many data bytes a channel message carries.
package midi_pkg;

  localparam logic [7:0] ST_NOTE_OFF   = 8'h80;
  localparam logic [7:0] ST_NOTE_ON    = 8'h90;
  localparam logic [7:0] ST_POLY_AT    = 8'hA0;
  localparam logic [7:0] ST_CC         = 8'hB0;
  localparam logic [7:0] ST_PROG       = 8'hC0;
  localparam logic [7:0] ST_CHAN_AT    = 8'hD0;
  localparam logic [7:0] ST_PITCH      = 8'hE0;
  localparam logic [7:0] ST_SYS_COMMON = 8'hF0;
  localparam logic [7:0] ST_REALTIME   = 8'hF8;

  typedef enum logic [1:0] {IDLE, D1, D2} state_t;

  // Program change and channel aftertouch carry one data byte, every other
  // channel message carries two.
  function automatic logic [1:0] data_bytes(input logic [7:0] status);
    logic [1:0] n;
    n = 2'd2;
    if (status[7:4] == ST_PROG[7:4] || status[7:4] == ST_CHAN_AT[7:4])
      n = 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/midi_cc_slew.sv
// midi_cc_slew -- rate limiter for the controller value. Accepted values
// become the target; every SLEW_DIV clocks cc_value moves one step toward it.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   accept, value   accepted controller value strobe and its 7-bit value
//   cc_value        slewed output value
//   cc_update       one-cycle pulse on every step
import midi_pkg::*;

module midi_cc_slew #(
  parameter int INIT_VALUE = 127,
  parameter int SLEW_DIV   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic [6:0] value,
  output logic [6:0] cc_value,
  output logic       cc_update
);

  localparam int             CW   = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(SLEW_DIV - 1);
  localparam logic [6:0]     INIT = INIT_VALUE[6:0];

  logic [CW-1:0] cnt;
  logic [6:0]    target;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      target    <= INIT;
      cc_value  <= INIT;
      cc_update <= 1'b0;
    end else begin
      cc_update <= 1'b0;
      cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (accept) target <= value;
      // Step compares against the target held before this edge; a new target
      // simply redirects from wherever cc_value currently is.
      if (cnt == LAST && cc_value != target) begin
        cc_value  <= (cc_value < target) ? cc_value + 7'd1 : cc_value - 7'd1;
        cc_update <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_cc_decoder.sv
// midi_cc_decoder -- parses a MIDI byte stream (running status, real-time
// interleave, system common abort) and tracks one control-change value.
// Optional slew limiting is compiled in with macro MIDI_CC_SLEW_EN.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rx_data, rx_valid    received byte and its one-cycle qualifier
//   cc_value             held controller value
//   cc_update            one-cycle pulse whenever cc_value changes
import midi_pkg::*;

module midi_cc_decoder #(
  parameter int CHANNEL    = 0,
  parameter int CC_NUM     = 7,
  parameter int INIT_VALUE = 127,
  parameter int SLEW_DIV   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] cc_value,
  output logic       cc_update
);

  localparam logic [7:0] CC_STATUS = ST_CC | {4'h0, CHANNEL[3:0]};
  localparam logic [6:0] CC_SEL    = CC_NUM[6:0];
  localparam logic [6:0] INIT      = INIT_VALUE[6:0];

  state_t     state;
  logic [7:0] run_status;   // 0 means no running status
  logic [6:0] byte1;
  logic       accept;
  logic [6:0] value;

  // Value byte of a matching control change completes in D2.
  assign value  = rx_data[6:0];
  assign accept = rx_valid && !rx_data[7] && state == D2 &&
                  run_status == CC_STATUS && byte1 == CC_SEL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_status <= '0;
      byte1      <= '0;
    end else if (rx_valid) begin
      if (rx_data >= ST_REALTIME) begin
        // real-time bytes pass through without touching the parser
      end else if (rx_data >= ST_SYS_COMMON) begin
        state      <= IDLE;
        run_status <= '0;
      end else if (rx_data[7]) begin
        // any channel status, including one arriving mid-message, restarts
        state      <= D1;
        run_status <= rx_data;
      end else begin
        case (state)
          D1: begin
            byte1 <= rx_data[6:0];
            state <= (data_bytes(run_status) == 2'd2) ? D2 : D1;
          end
          D2:      state <= D1;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MIDI_CC_SLEW_EN
  midi_cc_slew #(
    .INIT_VALUE (INIT_VALUE),
    .SLEW_DIV   (SLEW_DIV)
  ) u_slew (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .value     (value),
    .cc_value  (cc_value),
    .cc_update (cc_update)
  );
`else
  // SLEW_DIV only matters in the slewed build.
  logic unused_slew_div;
  assign unused_slew_div = ^SLEW_DIV;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_value  <= INIT;
      cc_update <= 1'b0;
    end else begin
      cc_update <= 1'b0;
      if (accept && value != cc_value) begin
        cc_value  <= value;
        cc_update <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_midi_cc_decoder.sv
// tb_midi_cc_decoder -- directed and randomized byte streams checked every
// cycle against a message-level model of the parser (MIDI_CC_SLEW_EN aware).
module tb_midi_cc_decoder;

  localparam int CH   = 0;
  localparam int CCN  = 7;
  localparam int INIT = 127;
  localparam int DIV  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] cc_value;
  logic       cc_update;

  always #5 clk = ~clk;

  midi_cc_decoder #(
    .CHANNEL    (CH),
    .CC_NUM     (CCN),
    .INIT_VALUE (INIT),
    .SLEW_DIV   (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cc_value  (cc_value),
    .cc_update (cc_update)
  );

  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;
  int   cyc      = 0;
  bit   chk_en   = 0;
  logic last_upd;

  // Model: running status (-1 = none) plus the data bytes of the message
  // currently being collected.
  int         m_rs  = -1;
  logic [7:0] mq[$];
  logic [6:0] m_val = 7'(INIT);
  logic [6:0] m_tgt = 7'(INIT);
  logic       m_upd = 1'b0;
  int         m_cnt = 0;

  function automatic int msg_len(input int st);
    int cls;
    cls = st / 16;
    return (cls == 12 || cls == 13) ? 1 : 2;
  endfunction

  task automatic model(input logic v, input logic [7:0] d, input logic r);
    bit         acc;
    logic [6:0] nv;
    acc   = 0;
    nv    = '0;
    m_upd = 1'b0;
    if (r) begin
      m_rs = -1; mq.delete(); m_val = 7'(INIT); m_tgt = 7'(INIT); m_cnt = 0;
    end else begin
      if (v) begin
        if (d >= 8'hF8) begin
        end else if (d >= 8'hF0) begin
          m_rs = -1; mq.delete();
        end else if (d[7]) begin
          m_rs = int'(d); mq.delete();
        end else if (m_rs >= 0) begin
          mq.push_back(d);
          if (mq.size() == msg_len(m_rs)) begin
            if (m_rs == (176 + CH) && int'(mq[0]) == CCN) begin
              acc = 1; nv = mq[mq.size()-1][6:0];
            end
            mq.delete();
          end
        end
      end
`ifdef MIDI_CC_SLEW_EN
      if (m_cnt == DIV-1 && m_val != m_tgt) begin
        m_val = (m_val < m_tgt) ? m_val + 7'd1 : m_val - 7'd1;
        m_upd = 1'b1;
      end
      m_cnt = (m_cnt + 1) % DIV;
      if (acc) m_tgt = nv;
`else
      if (acc && nv != m_val) begin
        m_val = nv; m_upd = 1'b1;
      end
`endif
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // One clock: apply inputs, let the edge happen, then compare at negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v; rx_data = d; rst = r;
    @(posedge clk);
    model(v, d, r);
    cyc++;
    @(negedge clk);
    if (chk_en) begin
      chk("cc_value", 32'(cc_value), 32'(m_val));
      chk("cc_update", 32'(cc_update), 32'(m_upd));
    end
    last_upd = cc_update;
    if (cc_update === 1'b1) pulses++;
  endtask

  task automatic sendb(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int         p;
    logic [7:0] b;
    rx_valid = 1'b0; rx_data = 8'h00; rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk_en = 1;
    do_reset();
    chk("reset_value", 32'(cc_value), 32'h7F);
    chk("reset_update", 32'(cc_update), 32'h0);

`ifndef MIDI_CC_SLEW_EN
    p = pulses;
    sendb(8'hB0); sendb(8'h07); sendb(8'h40);
    chk("basic_pulse", 32'(last_upd), 32'h1);
    chk("basic_value", 32'(cc_value), 32'h40);
    step(1'b0, 8'h00, 1'b0);
    chk("basic_pulse_cleared", 32'(cc_update), 32'h0);
    chk("basic_pulses", 32'(pulses - p), 32'd1);

    p = pulses;
    sendb(8'hB0); sendb(8'h07); sendb(8'h10);
    chk("running_first", 32'(cc_value), 32'h10);
    sendb(8'h07); sendb(8'h20);
    chk("running_second", 32'(cc_value), 32'h20);
    chk("running_pulses", 32'(pulses - p), 32'd2);
    p = pulses;
    sendb(8'h07); sendb(8'h20);
    chk("same_value_no_pulse", 32'(pulses - p), 32'd0);

    do_reset();
    p = pulses;
    sendb(8'hB1); sendb(8'h07); sendb(8'h55);
    sendb(8'hB0); sendb(8'h0A); sendb(8'h55);
    sendb(8'hC0); sendb(8'h07);
    chk("filter_value", 32'(cc_value), 32'h7F);
    chk("filter_pulses", 32'(pulses - p), 32'd0);

    sendb(8'hB0); sendb(8'h07); sendb(8'hF8); sendb(8'h33);
    chk("realtime_value", 32'(cc_value), 32'h33);
    p = pulses;
    sendb(8'hB0); sendb(8'h07); sendb(8'hF0); sendb(8'h33);
    sendb(8'h07); sendb(8'h44);
    chk("syscommon_value", 32'(cc_value), 32'h33);
    sendb(8'hB0); sendb(8'h07); sendb(8'h90); sendb(8'h40); sendb(8'h41);
    chk("abandon_value", 32'(cc_value), 32'h33);
    chk("syscommon_pulses", 32'(pulses - p), 32'd0);

    sendb(8'hB0); sendb(8'h07);
    do_reset();
    p = pulses;
    sendb(8'h22);
    step(1'b0, 8'h00, 1'b0);
    chk("reset_mid_value", 32'(cc_value), 32'h7F);
    chk("reset_mid_pulses", 32'(pulses - p), 32'd0);
`else
    begin
      int         pc[$];
      logic [6:0] pv[$];
      sendb(8'hB0); sendb(8'h07); sendb(8'h7C);
      if (last_upd) begin pc.push_back(cyc); pv.push_back(cc_value); end
      for (int i = 0; i < 40; i++) begin
        step(1'b0, 8'h00, 1'b0);
        if (last_upd) begin pc.push_back(cyc); pv.push_back(cc_value); end
      end
      chk("slew_pulses", 32'(pc.size()), 32'd3);
      chk("slew_final", 32'(cc_value), 32'h7C);
      if (pc.size() == 3) begin
        chk("slew_step1", 32'(pv[0]), 32'h7E);
        chk("slew_step2", 32'(pv[1]), 32'h7D);
        chk("slew_step3", 32'(pv[2]), 32'h7C);
        chk("slew_gap1", 32'(pc[1] - pc[0]), 32'd4);
        chk("slew_gap2", 32'(pc[2] - pc[1]), 32'd4);
      end
    end
`endif

    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 9:    b = 8'hB0 | 8'(CH);
        1, 8:    b = 8'(CCN);
        2, 3:    b = 8'($urandom_range(0, 127));
        4:       b = 8'($urandom_range(128, 239));
        5:       b = 8'($urandom_range(248, 255));
        6:       b = 8'($urandom_range(240, 247));
        default: b = 8'hB0 | 8'((CH + 1) % 16);
      endcase
      step($urandom_range(0, 3) != 0, b, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_cc_decoder.md
MIDI_CC_DECODER -- requirements
Module: midi_cc_decoder

Interface
REQ-001 SHALL have parameter CHANNEL, default 0, MIDI channel 0-15 to accept.
REQ-002 SHALL have parameter CC_NUM, default 7, controller number 0-127 to track.
REQ-003 SHALL have parameter INIT_VALUE, default 127, cc_value after reset.
REQ-004 SHALL have parameter SLEW_DIV, default 256, clocks per slew step (used only with MIDI_CC_SLEW_EN).
REQ-005 SHALL have port clk input 1, system clock; all logic on rising edge.
REQ-006 SHALL have port rst input 1, synchronous, active-high reset.
REQ-007 SHALL have port rx_data input 8, received MIDI byte from UART receiver.
REQ-008 SHALL have port rx_valid input 1, one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port cc_value output 7, held controller value; feeds the attenuator magnitude input.
REQ-010 SHALL have port cc_update output 1, one-cycle pulse when cc_value changes.

Function
REQ-011 SHALL examine rx_data only in cycles with rx_valid=1; other cycles change no state.
REQ-012 SHALL classify bytes: bit7=1 status; 0xF8-0xFF real-time; 0xF0-0xF7 system common; others data.
REQ-013 SHALL ignore real-time bytes completely: no change to state, running status or outputs, even mid-message.
REQ-014 SHALL, on system common byte, clear running status and go to IDLE; following data bytes (SysEx payload) discarded.
REQ-015 SHALL, on channel status 0x80-0xEF, store it as running status and go to D1.
REQ-016 SHALL use FSM states IDLE, D1, D2: IDLE discards data bytes; D1 on data byte captures byte1 then goes to D2 for 2-byte classes (0x8,0x9,0xA,0xB,0xE) or stays D1 for 1-byte classes (0xC,0xD); D2 on data byte completes message and returns to D1 (running status).
REQ-017 SHALL accept a message only if running status == 0xB0|CHANNEL and byte1 == CC_NUM; value = byte2[6:0].
REQ-018 SHALL, without slew, register cc_value = value and pulse cc_update on the clock edge that samples the value byte (latency 1 cycle); if value equals current cc_value, no cc_update pulse.
REQ-019 SHALL, on a status byte arriving in D2, abandon the partial message without update.
REQ-020 SHALL hold cc_update low in all cycles except those defined in REQ-018/REQ-026.

Reset
REQ-021 SHALL, on rst=1, set state IDLE, running status cleared, cc_value=INIT_VALUE, cc_update=0, slew counter 0, target=INIT_VALUE.
REQ-022 SHALL give rst priority over rx_valid in the same cycle; a message interrupted by reset is discarded.

Configuration
REQ-023 SHALL compile slew limiting in only when macro MIDI_CC_SLEW_EN is defined.
REQ-024 SHALL, with MIDI_CC_SLEW_EN, write accepted values to an internal target register instead of cc_value.
REQ-025 SHALL, with MIDI_CC_SLEW_EN, run a counter 0..SLEW_DIV-1, wrapping; on wrap, if cc_value != target, step cc_value by exactly 1 toward target.
REQ-026 SHALL, with MIDI_CC_SLEW_EN, pulse cc_update on each step; a new target mid-slew redirects from current cc_value.
REQ-027 SHALL, without MIDI_CC_SLEW_EN, behave per REQ-018 with no counter or target logic.

Structure
REQ-028 SHALL place status-class constants (0x80..0xE0, 0xF0, 0xF8), FSM state typedef and data-byte-count function in shared package midi_pkg.
REQ-029 SHALL implement slew logic as sub-module midi_cc_slew, instantiated only under MIDI_CC_SLEW_EN.
REQ-030 SHALL be 120-400 lines of RTL total.

Verification
REQ-031 SHALL test: bytes B0,07,40 -> cc_value=0x40, one cc_update pulse one cycle after 0x40 sampled.
REQ-032 SHALL test running status: B0,07,10 then 07,20 -> cc_value 0x10 then 0x20, two pulses.
REQ-033 SHALL test filtering: B1,07,55 and B0,0A,55 and C0,07 -> cc_value stays 127, no pulse.
REQ-034 SHALL test interleave: B0,07,F8,33 -> cc_value=0x33; B0,07,F0,33 -> no update, state IDLE.
REQ-035 SHALL test reset mid-message: B0,07, rst, 22 -> cc_value=127, no pulse.
REQ-036 SHALL test with MIDI_CC_SLEW_EN, SLEW_DIV=4: B0,07,7C from 127 -> three steps 126,125,124 every 4 clocks, three pulses.
